// File: rtl/zprize_result_packer.sv
// Serializes DATA_W-bit result points into NBEAT output beats (LSB slice first)
// and tracks group boundaries of PTS_PER_GRP points for the DDR write path.
module zprize_result_packer #(
    parameter int DATA_W      = 1536,
    parameter int OUT_W       = 512,
    parameter int PTS_PER_GRP = 256,
    localparam int NBEAT      = DATA_W / OUT_W,
    localparam int BEAT_W     = (NBEAT > 1) ? $clog2(NBEAT) : 1,
    localparam int CNT_W      = (PTS_PER_GRP > 1) ? $clog2(PTS_PER_GRP) : 1
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic              grp_done,
    output logic [CNT_W-1:0]  pt_cnt
);

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NBEAT - 1);
    localparam logic [CNT_W-1:0]  PT_LAST   = CNT_W'(PTS_PER_GRP - 1);

    if (DATA_W % OUT_W != 0) begin : g_bad_width
        $error("DATA_W must be an integer multiple of OUT_W");
    end

    logic [DATA_W-1:0] hold;
    logic              hold_valid;
    logic [BEAT_W-1:0] beat;
    logic              out_fire;
    logic              pt_done;
    logic              in_fire;
    logic              grp_end;

    assign out_valid = hold_valid;
    assign out_fire  = out_valid && out_ready;
    assign pt_done   = out_fire && (beat == BEAT_LAST);
    assign grp_end   = pt_done && (pt_cnt == PT_LAST);
    // A completing point frees the hold register in the same cycle, so
    // back-to-back points stream without a bubble.
    assign in_ready  = !clear && (!hold_valid || pt_done);
    assign in_fire   = in_valid && in_ready;

    assign out_data  = hold[beat*OUT_W +: OUT_W];
    assign out_last  = out_valid && (beat == BEAT_LAST) && (pt_cnt == PT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            hold_valid <= 1'b0;
            beat       <= '0;
            pt_cnt     <= '0;
            grp_done   <= 1'b0;
        end else if (clear) begin
            hold_valid <= 1'b0;
            beat       <= '0;
            pt_cnt     <= '0;
            grp_done   <= 1'b0;
        end else begin
            grp_done <= grp_end;
            if (in_fire) begin
                hold_valid <= 1'b1;
                beat       <= '0;
            end else if (pt_done) begin
                hold_valid <= 1'b0;
                beat       <= '0;
            end else if (out_fire) begin
                beat <= beat + 1'b1;
            end
            if (pt_done) begin
                pt_cnt <= grp_end ? '0 : pt_cnt + 1'b1;
            end
        end
    end

    // NOTE: the wide data register has no reset; hold_valid qualifies it, and
    // leaving it unreset avoids a reset net fanning out to DATA_W flops.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            hold <= in_data;
        end
    end

endmodule

// File: doc/zprize_result_packer.md
ZPRIZE_RESULT_PACKER -- requirements
Module: zprize_result_packer

Interface
REQ-001 Parameter DATA_W, default 1536, width of one input result point.
REQ-002 Parameter OUT_W, default 512, output beat width; DATA_W SHALL be an integer multiple of OUT_W, giving NBEAT = DATA_W/OUT_W (default 3).
REQ-003 Parameter PTS_PER_GRP, default 256, result points per group (128 sections x {sum,tmp}).
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rstN  in  1  reset, asynchronous, active-low.
REQ-006 clear  in  1  synchronous abort: drops held point, zeroes counters.
REQ-007 in_valid  in  1  upstream result valid.
REQ-008 in_ready  out  1  packer can accept a point this cycle.
REQ-009 in_data  in  DATA_W  result point (sum or tmp of one section).
REQ-010 out_valid  out  1  output beat valid.
REQ-011 out_ready  in  1  downstream (DDR write path) accepts beat.
REQ-012 out_data  out  OUT_W  output beat.
REQ-013 out_last  out  1  final beat of final point of a group.
REQ-014 grp_done  out  1  one-cycle pulse, group fully emitted.
REQ-015 pt_cnt  out  log2(PTS_PER_GRP)  points fully emitted in current group.

Function
REQ-016 Storage: one DATA_W hold register plus hold_valid flag; beat index 0..NBEAT-1.
REQ-017 Input transfer occurs when in_valid && in_ready; in_data captured into hold register, hold_valid set, beat index set to 0.
REQ-018 in_ready = !clear && (!hold_valid || (out_valid && out_ready && beat==NBEAT-1)); back-to-back points SHALL stream with no bubble.
REQ-019 Latency: point accepted in cycle N -> beat 0 presented with out_valid=1 in cycle N+1.
REQ-020 out_valid = hold_valid; out_data = hold[(beat+1)*OUT_W-1 : beat*OUT_W], beat 0 = least-significant slice.
REQ-021 Beat index advances only on out_valid && out_ready; wraps NBEAT-1 -> 0 on point completion.
REQ-022 While out_valid && !out_ready, out_data, out_last and beat index SHALL hold stable.
REQ-023 Point completion (last beat accepted) without a same-cycle input transfer clears hold_valid.
REQ-024 pt_cnt increments on each point completion; at PTS_PER_GRP-1 completion wraps to 0.
REQ-025 out_last = out_valid && beat==NBEAT-1 && pt_cnt==PTS_PER_GRP-1.
REQ-026 grp_done pulses in cycle after the out_last beat is accepted.
REQ-027 clear: next cycle hold_valid=0, beat=0, pt_cnt=0, grp_done=0; an input presented with clear is not accepted; clear with an out_last handshake suppresses grp_done.
REQ-028 No data reordering, duplication or loss: output beat stream equals input points serialized LSB-slice first.

Reset
REQ-029 On rstN low (asynchronous): hold_valid=0, beat=0, pt_cnt=0, out_valid=0, out_last=0, grp_done=0; in_ready=1 once rstN high and clear low.
REQ-030 Reset asserted mid-point discards the partial point; first point after reset starts at beat 0, pt_cnt 0.
REQ-031 Hold register data need not be reset; out_data is don't-care while out_valid=0.

Verification
REQ-032 Single point 0x...0003_...0002_...0001 (slices 1,2,3), out_ready=1 -> out_data 1,2,3 in cycles N+1..N+3, out_last=0, pt_cnt=1.
REQ-033 256 points streamed, out_ready=1 -> 768 contiguous beats, in_ready low 2 of every 3 cycles, out_last only on beat 768, grp_done next cycle, pt_cnt back to 0.
REQ-034 out_ready toggled random 50% -> beats held stable while stalled, stream matches scoreboard exactly, no extra in_ready.
REQ-035 clear asserted after beat 1 of point 10 with in_valid high -> that point dropped, input not taken, next point begins beat 0, pt_cnt 0.
REQ-036 rstN pulsed low mid-beat of point 255 -> out_valid 0 immediately, no grp_done; next 256 points produce correct out_last.
REQ-037 Two groups back-to-back -> out_last and grp_done exactly once per group, no bubble between groups.
